fetch_unit: RTL and testbench

Instruction fetch sequencer for the MIPS core. It owns the program counter and drives `readAddress` of `instruction_memory`, which has a one-cycle registered read. It captures the returned words into a small prefetch buffer and presents them to decode over a valid/ready handshake. It also services branch/jump redirects by flushing in-flight and buffered fetches.

---
 rtl/mips_fetch_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 73 +++++++
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared widths, PC step and fetch-entry types for the fetch path
package mips_fetch_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int ADDR_WIDTH  = 32;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]  pc;
      logic [INSTR_WIDTH-1:0] word;
   } fetch_entry_t;

   typedef enum logic {
      ST_RESET = 1'b0,
      ST_RUN   = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - DEPTH-entry synchronous FIFO of {pc, word} with flush
module fetch_buffer
   import mips_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               flush,
   input  logic               push,
   input  fetch_entry_t       push_entry,
   input  logic               pop,
   output logic [CNT_W-1:0]   count,
   output fetch_entry_t       head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_eff;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop_eff  = pop && (count_q != '0);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = next_ptr(wr_ptr_q);
         end
         if (pop_eff) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Empty buffer presents zeros so decode never sees stale words after a flush.
   assign count = count_q;
   assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, request issue, prefetch capture and redirect flush
module fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
   parameter int                    DEPTH    = 2
) (
   input  logic                   clk,
   input  logic                   resetN,
   output logic [ADDR_WIDTH-1:0]  readAddress,
   input  logic [INSTR_WIDTH-1:0] instruction,
   input  logic                   redirectValid,
   input  logic [ADDR_WIDTH-1:0]  redirectAddress,
   output logic                   instrValid,
   output logic [INSTR_WIDTH-1:0] instrOut,
   output logic [ADDR_WIDTH-1:0]  instrPc,
   input  logic                   instrReady
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
   logic                  req_valid_q, req_valid_d;

   logic [CNT_W-1:0]      count;
   logic [CNT_W:0]        occupancy;
   fetch_entry_t          head;
   fetch_entry_t          push_entry;
   logic                  redirect, pop, push, issue;

   always_comb begin
      state_d     = ST_RUN;
      redirect    = redirectValid && (state_q == ST_RUN);
      pop         = instrValid && instrReady;
      push        = req_valid_q && !redirect;
      // Occupancy after this edge, counting the in-flight word as already buffered.
      occupancy   = (CNT_W+1)'(count) + (CNT_W+1)'(req_valid_q) - (CNT_W+1)'(pop);
      issue       = !redirect && (occupancy < (CNT_W+1)'(DEPTH));
      push_entry  = '{pc: req_pc_q, word: instruction};
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = req_pc_q;
      req_valid_d = issue;
      if (redirect) begin
         fetch_pc_d = {redirectAddress[ADDR_WIDTH-1:2], 2'b00};
      end else if (issue) begin
         req_pc_d   = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q     <= ST_RESET;
         fetch_pc_q  <= RESET_PC;
         req_pc_q    <= '0;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
      end
   end

   fetch_buffer #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fetch_buffer (
      .clk        (clk),
      .resetN     (resetN),
      .flush      (redirect),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .count      (count),
      .head       (head)
   );

   assign readAddress = fetch_pc_q;
   assign instrValid  = (count != '0);
   assign instrOut    = head.word;
   assign instrPc     = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a word@addr = addr+1 memory
module tb_fetch_unit;

   logic        clk;
   logic        resetN;
   logic [31:0] readAddress;
   logic [31:0] instruction;
   logic        redirectValid;
   logic [31:0] redirectAddress;
   logic        instrValid;
   logic [31:0] instrOut;
   logic [31:0] instrPc;
   logic        instrReady;

   int total;
   int passed;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk             (clk),
      .resetN          (resetN),
      .readAddress     (readAddress),
      .instruction     (instruction),
      .redirectValid   (redirectValid),
      .redirectAddress (redirectAddress),
      .instrValid      (instrValid),
      .instrOut        (instrOut),
      .instrPc         (instrPc),
      .instrReady      (instrReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle registered instruction memory.
   always @(posedge clk) instruction <= readAddress + 32'd1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_instr(input string tag, input logic [31:0] pc);
      chk({tag, ".valid"}, {31'd0, instrValid}, 32'd1);
      chk({tag, ".pc"}, instrPc, pc);
      chk({tag, ".word"}, instrOut, pc + 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".addr"}, readAddress, 32'h0);
      chk({tag, ".valid"}, {31'd0, instrValid}, 32'd0);
      chk({tag, ".out"}, instrOut, 32'h0);
      chk({tag, ".pc"}, instrPc, 32'h0);
   endtask

   initial begin
      total           = 0;
      passed          = 0;
      resetN          = 1'b0;
      instrReady      = 1'b1;
      redirectValid   = 1'b0;
      redirectAddress = 32'h0;
      step();
      step();
      chk_reset_outputs("reset");

      // Release: valid rises exactly two edges later, then one instruction per cycle.
      resetN = 1'b1;
      step();
      chk("e0.valid", {31'd0, instrValid}, 32'd0);
      chk("e0.addr", readAddress, 32'h4);
      step();
      chk_instr("e1", 32'h0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk_instr($sformatf("stream%0d", k), 32'(4 * k));
      end

      // Mid-stream one-cycle reset, then restart with backpressure from first valid.
      resetN     = 1'b0;
      instrReady = 1'b0;
      step();
      chk_reset_outputs("midreset");
      resetN = 1'b1;
      step();
      chk("restart.e0.valid", {31'd0, instrValid}, 32'd0);
      step();
      for (int k = 0; k < 5; k++) begin
         chk_instr($sformatf("stall%0d", k), 32'h0);
         chk($sformatf("stall%0d.addr", k), readAddress, 32'h8);
         if (k < 4) step();
      end
      instrReady = 1'b1;
      step();
      chk_instr("release0", 32'h4);
      step();
      chk_instr("release1", 32'h8);
      step();
      chk_instr("release2", 32'hC);

      // Fill both entries again, then redirect with the buffer full.
      instrReady = 1'b0;
      step();
      chk_instr("fill", 32'hC);
      chk("fill.addr", readAddress, 32'h14);
      redirectValid   = 1'b1;
      redirectAddress = 32'h0000_0105;
      step();
      redirectValid = 1'b0;
      instrReady    = 1'b1;
      chk("redir.valid", {31'd0, instrValid}, 32'd0);
      chk("redir.addr", readAddress, 32'h104);
      step();
      chk("redir1.valid", {31'd0, instrValid}, 32'd0);
      chk("redir1.addr", readAddress, 32'h108);
      step();
      chk_instr("redir2", 32'h104);
      step();
      chk_instr("redir3", 32'h108);
      step();
      chk_instr("redir4", 32'h10C);

      // Redirect on a pop edge (0x10C consumed, 0x110 in flight dropped) into the wrap.
      redirectValid   = 1'b1;
      redirectAddress = 32'hFFFF_FFF8;
      step();
      redirectValid = 1'b0;
      chk("wrap.valid", {31'd0, instrValid}, 32'd0);
      chk("wrap.addr", readAddress, 32'hFFFF_FFF8);
      step();
      chk("wrap1.valid", {31'd0, instrValid}, 32'd0);
      step();
      chk_instr("wrap2", 32'hFFFF_FFF8);
      step();
      chk_instr("wrap3", 32'hFFFF_FFFC);
      chk("wrap3.addr", readAddress, 32'h4);
      step();
      chk_instr("wrap4", 32'h0000_0000);
      step();
      chk_instr("wrap5", 32'h0000_0004);

      // Redirect held through reset and the release edge is ignored.
      resetN          = 1'b0;
      redirectValid   = 1'b1;
      redirectAddress = 32'h0000_0200;
      step();
      chk_reset_outputs("rst_redir");
      resetN = 1'b1;
      step();
      redirectValid = 1'b0;
      chk("rst_redir.e0.addr", readAddress, 32'h4);
      chk("rst_redir.e0.valid", {31'd0, instrValid}, 32'd0);
      step();
      chk_instr("rst_redir.e1", 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
